memif_burst: RTL

MEMIF_BURST -- requirements
Module: memif_burst

---
 rtl/memif_pkg.sv | 35 +++
 rtl/memif_packet_codec.sv | 28 ++
 rtl/memif_burst.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/memif_pkg.sv
// Shared types and field helpers for the banked burst memory interface.
// Packets carry one data word split in halves, each half behind a 2-bit tag.
package memif_pkg;

  typedef enum logic [1:0] {
    MODE_RW  = 2'b00,
    MODE_RO  = 2'b01,
    MODE_WO  = 2'b10,
    MODE_RSV = 2'b11
  } mode_e;

  typedef enum logic [2:0] {
    ST_HEADER,
    ST_WADDR,
    ST_STREAM,
    ST_DONE,
    ST_ERROR
  } state_e;

  localparam logic [1:0] TAG_HI = 2'b01;
  localparam logic [1:0] TAG_LO = 2'b10;

  function automatic int mode_lsb(int aw, int bb);
    return aw + bb;
  endfunction

  function automatic int bank_lsb(int aw);
    return aw;
  endfunction

  function automatic int len_lsb(int aw);
    return aw;
  endfunction

endpackage

// File: rtl/memif_packet_codec.sv
// Tagged packet pack/unpack: {TAG_HI, upper half, TAG_LO, lower half}.
// The receive side also reports whether both tag pairs are intact.
module memif_packet_codec
  import memif_pkg::*;
#(
  parameter int WORD_WIDTH = 36,
  localparam int PW = WORD_WIDTH + 4,
  localparam int HALF = WORD_WIDTH / 2
) (
  input  logic [PW-1:0]         rx_packet,
  output logic [WORD_WIDTH-1:0] rx_word,
  output logic                  rx_valid,
  input  logic [WORD_WIDTH-1:0] tx_word,
  output logic [PW-1:0]         tx_packet
);

  assign rx_valid = (rx_packet[PW-1 -: 2] == TAG_HI)
                 && (rx_packet[HALF +: 2] == TAG_LO);

  assign rx_word = {rx_packet[HALF+2 +: HALF],
                    rx_packet[HALF-1:0]};

  assign tx_packet = {TAG_HI,
                      tx_word[WORD_WIDTH-1 -: HALF],
                      TAG_LO,
                      tx_word[HALF-1:0]};

endmodule

// File: rtl/memif_burst.sv
// Packet-driven burst engine: header, write-address beat, then streaming
// beats that read one bank and optionally write the same bank.
module memif_burst
  import memif_pkg::*;
#(
  parameter int WORD_WIDTH = 36,
  parameter int ADDR_WIDTH = 10,
  parameter int NUM_BANKS = 4,
  parameter int LEN_WIDTH = 10,
  parameter int ERR_WIDTH = 8,
  localparam int BANK_BITS = $clog2(NUM_BANKS),
  localparam int PACKET_WIDTH = WORD_WIDTH + 4
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            dataReady,
  input  logic [PACKET_WIDTH-1:0]         inPacket,
  output logic [PACKET_WIDTH-1:0]         outPacket,
  output logic [ADDR_WIDTH-1:0]           rd_addr,
  input  logic [NUM_BANKS*WORD_WIDTH-1:0] rd_data,
  output logic [ADDR_WIDTH-1:0]           wr_addr,
  output logic [WORD_WIDTH-1:0]           wr_data,
  output logic [NUM_BANKS-1:0]            wr_enable,
  output logic                            inPacketIsValid,
  output logic                            done,
  output logic                            error,
  output logic [ERR_WIDTH-1:0]            invalidCount
);

  localparam int MODE_LSB = mode_lsb(ADDR_WIDTH, BANK_BITS);
  localparam int BANK_LSB = bank_lsb(ADDR_WIDTH);
  localparam int LEN_LSB = len_lsb(ADDR_WIDTH);

  state_e state, state_next;
  mode_e mode_q, mode_next;
  logic [BANK_BITS-1:0] bank_q, bank_next;
  logic [ADDR_WIDTH-1:0] rd_q, rd_next;
  logic [ADDR_WIDTH-1:0] wr_q, wr_next;
  logic [LEN_WIDTH-1:0] rem_q, rem_next;
  logic done_q, done_next;
  logic err_q, err_next;
  logic [ERR_WIDTH-1:0] inv_q, inv_next;

  logic [WORD_WIDTH-1:0] rx_word;
  logic [WORD_WIDTH-1:0] rd_word;
  logic [PACKET_WIDTH-1:0] tx_packet;
  logic rx_valid;

  memif_packet_codec #(
    .WORD_WIDTH(WORD_WIDTH)
  ) codec (
    .rx_packet(inPacket),
    .rx_word  (rx_word),
    .rx_valid (rx_valid),
    .tx_word  (rd_word),
    .tx_packet(tx_packet)
  );

  mode_e f_mode;
  logic [BANK_BITS-1:0] f_bank;
  logic [ADDR_WIDTH-1:0] f_addr;
  logic [LEN_WIDTH-1:0] f_len;

  assign f_mode = mode_e'(rx_word[MODE_LSB +: 2]);
  assign f_bank = rx_word[BANK_LSB +: BANK_BITS];
  assign f_addr = rx_word[ADDR_WIDTH-1:0];
  assign f_len = rx_word[LEN_LSB +: LEN_WIDTH];

  logic in_header;
  logic [BANK_BITS-1:0] sel_bank;
  mode_e sel_mode;
  logic out_zero;

  // The header beat reads straight from the incoming fields.
  assign in_header = (state == ST_HEADER);
  assign sel_bank = in_header ? f_bank : bank_q;
  assign sel_mode = in_header ? f_mode : mode_q;
  assign rd_addr = in_header ? f_addr : rd_q;
  assign rd_word = rd_data[sel_bank*WORD_WIDTH +: WORD_WIDTH];

  assign out_zero = (state == ST_DONE)
                 || (state == ST_ERROR)
                 || (sel_mode == MODE_WO);
  assign outPacket = out_zero ? '0 : tx_packet;

  assign inPacketIsValid = rx_valid;
  assign wr_addr = wr_q;
  assign wr_data = rx_word;
  assign done = done_q;
  assign error = err_q;
  assign invalidCount = inv_q;

  always_comb begin
    state_next = state;
    mode_next = mode_q;
    bank_next = bank_q;
    rd_next = rd_q;
    wr_next = wr_q;
    rem_next = rem_q;
    done_next = done_q;
    err_next = err_q;
    inv_next = inv_q;
    wr_enable = '0;
    if (dataReady && !reset) begin
      case (state)
        ST_HEADER: begin
          if (!rx_valid || f_mode == MODE_RSV) begin
            state_next = ST_ERROR;
            err_next = 1'b1;
          end else begin
            mode_next = f_mode;
            bank_next = f_bank;
            rd_next = f_addr;
            state_next = ST_WADDR;
          end
        end
        ST_WADDR: begin
          if (!rx_valid) begin
            state_next = ST_ERROR;
            err_next = 1'b1;
          end else begin
            rem_next = f_len;
            wr_next = f_addr;
            rd_next = rd_q + 1'b1;
            state_next = ST_STREAM;
          end
        end
        ST_STREAM: begin
          if (rx_valid && mode_q != MODE_RO)
            wr_enable = NUM_BANKS'(1) << bank_q;
          if (!rx_valid && inv_q != '1)
            inv_next = inv_q + 1'b1;
          rd_next = rd_q + 1'b1;
          wr_next = wr_q + 1'b1;
          // A zero length never counts down, so the burst is unbounded.
          if (rem_q == LEN_WIDTH'(1)) begin
            rem_next = '0;
            done_next = 1'b1;
            state_next = ST_DONE;
          end else if (rem_q != '0) begin
            rem_next = rem_q - 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_HEADER;
      mode_q <= MODE_RW;
      bank_q <= '0;
      rd_q <= '0;
      wr_q <= '0;
      rem_q <= '0;
      done_q <= 1'b0;
      err_q <= 1'b0;
      inv_q <= '0;
    end else begin
      state <= state_next;
      mode_q <= mode_next;
      bank_q <= bank_next;
      rd_q <= rd_next;
      wr_q <= wr_next;
      rem_q <= rem_next;
      done_q <= done_next;
      err_q <= err_next;
      inv_q <= inv_next;
    end
  end

endmodule
